ascii_store_queue: RTL and testbench

Buffers character-cell stores that the processor sends to the text-mode VGA path. Accepts byte, half-word and word stores on a ready/valid port, holds them in a small FIFO, and drains each store into one or more single-character writes to the ASCII text buffer in `ascii_master_controller`. It sits between the processor's memory-mapped VGA store path and the text controller, so stores never get dropped while the controller is busy.

---
 rtl/ascii_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/ascii_store_queue.sv | 137 +++++++++++++
 tb/tb_ascii_store_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// ============================================================================
// Module   : ascii_pkg
// Brief    : Shared store-size encodings, drain FSM states and helpers for
//            the ASCII text store path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ascii_pkg;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [0:0] {
        Q_IDLE = 1'b0,
        Q_EMIT = 1'b1
    } q_state_t;

    // Index of the final character a store of the given size produces.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SIZE_HALF: last_index = 2'd1;
            SIZE_WORD: last_index = 2'd3;
            default:   last_index = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Synchronous FIFO using circular pointers with an extra wrap bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    // Same slot index with differing wrap bits means the pointers are a lap apart.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/ascii_store_queue.sv
// ============================================================================
// Module   : ascii_store_queue
// Brief    : Queues byte/half/word character stores and drains them as
//            single-character writes to the ASCII text buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ascii_store_queue
    import ascii_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_size,
    input  logic [ADDR_WIDTH-1:0] in_address,
    input  logic [WORD_SIZE-1:0]  in_data,
    output logic                  out_write_en,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic [7:0]            out_char,
    output logic                  full,
    output logic                  busy,
    output logic                  overflow_error
);

    localparam int EW = 2 + ADDR_WIDTH + WORD_SIZE;

    logic                    push;
    logic                    pop;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic [EW-1:0]           head;
    logic [1:0]              head_size;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [WORD_SIZE-1:0]    head_data;

    q_state_t                state_q,  state_d;
    logic [1:0]              size_q,   size_d;
    logic [ADDR_WIDTH-1:0]   base_q,   base_d;
    logic [WORD_SIZE-1:0]    data_q,   data_d;
    logic [1:0]              idx_q,    idx_d;
    logic                    overflow_q;

    // Size-none stores are acknowledged but never occupy a FIFO slot.
    assign push     = in_valid && !full && (in_size != SIZE_NONE);
    assign in_ready = !full;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_size, in_address, in_data}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign {head_size, head_addr, head_data} = head;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        base_d  = base_q;
        data_d  = data_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            Q_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    size_d  = head_size;
                    base_d  = head_addr;
                    data_d  = head_data;
                    idx_d   = 2'd0;
                    state_d = Q_EMIT;
                end
            end
            Q_EMIT: begin
                if (out_ready) begin
                    if (idx_q == last_index(size_q)) begin
                        // Chain straight into the next store to avoid a bubble.
                        if (!empty) begin
                            pop    = 1'b1;
                            size_d = head_size;
                            base_d = head_addr;
                            data_d = head_data;
                            idx_d  = 2'd0;
                        end else begin
                            state_d = Q_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = Q_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= Q_IDLE;
            size_q     <= SIZE_NONE;
            base_q     <= '0;
            data_q     <= '0;
            idx_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            base_q     <= base_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_q | (in_valid & full);
        end
    end

    assign out_write_en   = (state_q == Q_EMIT);
    assign out_address    = out_write_en ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
    assign out_char       = out_write_en ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign busy           = (count != '0) || (state_q != Q_IDLE);
    assign overflow_error = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ascii_store_queue.sv
// ============================================================================
// Module   : tb_ascii_store_queue
// Brief    : Directed self-checking bench for ascii_store_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ascii_store_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_size;
    logic [12:0] in_address;
    logic [31:0] in_data;
    logic        out_write_en;
    logic        out_ready;
    logic [12:0] out_address;
    logic [7:0]  out_char;
    logic        full;
    logic        busy;
    logic        overflow_error;

    int total = 0;
    int bad   = 0;

    logic [20:0] caps [$];

    ascii_store_queue #(
        .WORD_SIZE  (32),
        .ADDR_WIDTH (13),
        .DEPTH      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_size        (in_size),
        .in_address     (in_address),
        .in_data        (in_data),
        .out_write_en   (out_write_en),
        .out_ready      (out_ready),
        .out_address    (out_address),
        .out_char       (out_char),
        .full           (full),
        .busy           (busy),
        .overflow_error (overflow_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed character write as {address, char}.
    always @(negedge clk) begin
        if (!rst && out_write_en && out_ready)
            caps.push_back({out_address, out_char});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sz, input logic [12:0] a, input logic [31:0] d);
        in_valid   = 1'b1;
        in_size    = sz;
        in_address = a;
        in_data    = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          ei;
        int          k;
        int          budget;
        logic        pat [4];

        rst = 1'b1; in_valid = 1'b0; in_size = 2'b00;
        in_address = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_we",    out_write_en,   0);
        chk("rst_ready", in_ready,       1);
        chk("rst_full",  full,           0);
        chk("rst_busy",  busy,           0);
        chk("rst_ovf",   overflow_error, 0);
        chk("rst_addr",  out_address,    0);
        chk("rst_char",  out_char,       0);
        rst = 1'b0;
        step();

        // Byte store: write appears two cycles after accept.
        out_ready = 1'b1;
        drive(2'b01, 13'h010, 32'h0000_0041);
        chk("byte_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("byte_t1_we",   out_write_en, 0);
        chk("byte_t1_busy", busy,         1);
        step();
        chk("byte_t2_we",   out_write_en, 1);
        chk("byte_t2_addr", out_address,  13'h010);
        chk("byte_t2_char", out_char,     8'h41);
        step();
        chk("byte_t3_we",   out_write_en, 0);
        chk("byte_t3_busy", busy,         0);

        // Word store: four consecutive characters.
        drive(2'b11, 13'h100, 32'h4443_4241);
        step();
        in_valid = 1'b0;
        chk("word_t1_we", out_write_en, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("word_we",   out_write_en, 1);
            chk("word_addr", out_address,  32'h100 + i);
            chk("word_char", out_char,     32'h41 + i);
            step();
        end
        chk("word_end_we", out_write_en, 0);

        // Back-pressure with out_ready cycling 1,0,0,1.
        caps.delete();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        out_ready = 1'b0;
        drive(2'b11, 13'h200, 32'h6463_6261);
        step();
        in_valid = 1'b0;
        step();
        ei = 0;
        k  = 0;
        while (ei < 4 && k < 20) begin
            out_ready = pat[k % 4];
            chk("bp_we",   out_write_en, 1);
            chk("bp_addr", out_address,  32'h200 + ei);
            chk("bp_char", out_char,     32'h61 + ei);
            step();
            if (out_ready) ei++;
            k++;
        end
        chk("bp_done", ei, 4);
        chk("bp_end_we", out_write_en, 0);
        chk("bp_count", caps.size(), 4);
        for (int i = 0; i < 4 && i < caps.size(); i++)
            chk("bp_cap", caps[i], {13'h200 + 13'(i), 8'h61 + 8'(i)});

        // Fill: one store sits in the holding registers, eight in the FIFO.
        caps.delete();
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < 4; j++) d[8*j +: 8] = 8'(32 + 4*s + j);
            drive(2'b11, 13'(32'h300 + 4*s), d);
            chk("fill_ready", in_ready, (s < 9) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        chk("fill_full", full,           1);
        chk("fill_ovf",  overflow_error, 1);
        repeat (3) step();
        chk("fill_ovf_sticky", overflow_error, 1);
        chk("fill_full_hold",  full,           1);
        out_ready = 1'b1;
        budget = 0;
        while (caps.size() < 36 && budget < 100) begin
            step();
            budget++;
        end
        chk("fill_count", caps.size(), 36);
        for (int n = 0; n < 36 && n < caps.size(); n++)
            chk("fill_cap", caps[n], {13'h300 + 13'(n), 8'(32 + n)});
        step();
        chk("fill_busy",    busy,           0);
        chk("fill_full_0",  full,           0);
        chk("fill_ovf_end", overflow_error, 1);

        // Half-word across the address wrap.
        caps.delete();
        drive(2'b10, 13'h1FFF, 32'h0000_4241);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("wrap_count", caps.size(), 2);
        if (caps.size() >= 2) begin
            chk("wrap_cap0", caps[0], {13'h1FFF, 8'h41});
            chk("wrap_cap1", caps[1], {13'h0000, 8'h42});
        end

        // Size-none store is acknowledged and dropped.
        caps.delete();
        drive(2'b00, 13'h005, 32'h0000_0055);
        chk("none_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("none_busy", busy, 0);
        repeat (4) step();
        chk("none_count", caps.size(), 0);
        chk("none_we",    out_write_en, 0);

        // Reset during the second character of a word store.
        caps.delete();
        drive(2'b11, 13'h400, 32'h5A59_5857);
        step();
        in_valid = 1'b0;
        step();
        chk("mrst_c0", out_char, 8'h57);
        step();
        chk("mrst_c1", out_char, 8'h58);
        rst = 1'b1;
        step();
        chk("mrst_we",    out_write_en,   0);
        chk("mrst_busy",  busy,           0);
        chk("mrst_ready", in_ready,       1);
        chk("mrst_full",  full,           0);
        chk("mrst_ovf",   overflow_error, 0);
        chk("mrst_addr",  out_address,    0);
        chk("mrst_char",  out_char,       0);
        rst = 1'b0;
        repeat (6) step();
        chk("mrst_count", caps.size(), 1);
        if (caps.size() >= 1)
            chk("mrst_cap0", caps[0], {13'h400, 8'h57});
        chk("mrst_end_we", out_write_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
